// File: rtl/push_pkg.sv
// Shared types and defaults for the push-button round-robin arbiter slice.
package push_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    localparam int unsigned DEF_N         = 8;
    localparam int unsigned DEF_HOLD_MAX  = 16;
    localparam int unsigned DEF_COOL      = 2;
    localparam int unsigned DEF_DB_CYCLES = 4;
    localparam int unsigned DEF_IDX_W     = $clog2(DEF_N);

endpackage

// File: rtl/push_rr_arbiter_if.sv
// Request/grant bundle between the button front end and the arbiter.
// slave = arbiter side, master = requester/resource side.
interface push_rr_arbiter_if
    import push_pkg::*;
#(
    parameter int unsigned N = DEF_N
);
    localparam int unsigned IW = $clog2(N);

    logic          enable;
    logic [N-1:0]  req;
    logic          ack;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [N-1:0]  pending;
    logic          busy;
    logic          timeout;

    modport slave (
        input  enable, req, ack,
        output gnt, gnt_idx, gnt_valid, pending, busy, timeout
    );

    modport master (
        output enable, req, ack,
        input  gnt, gnt_idx, gnt_valid, pending, busy, timeout
    );
endinterface

// File: rtl/push_rr_pick.sv
// Combinational round-robin pick: first pending bit at or after ptr, cyclically.
module push_rr_pick
    import push_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned IW = DEF_IDX_W
) (
    input  logic [N-1:0]  pending,
    input  logic [N-1:0]  ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any_valid
);
    logic [N-1:0] upper;
    logic [N-1:0] base;
    logic         found;

    // Bits at or above the pointer win first; otherwise wrap to the lowest pending bit.
    always_comb begin
        upper     = pending & ~(ptr - N'(1));
        base      = (|upper) ? upper : pending;
        win_oh    = '0;
        win_idx   = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (base[i] && !found) begin
                win_oh[i] = 1'b1;
                win_idx   = IW'(i);
                found     = 1'b1;
            end
        end
        any_valid = |pending;
    end
endmodule

// File: rtl/push_rr_arbiter.sv
// Round-robin arbiter for N push-button requesters sharing one resource.
// Optional input debounce filter: define PUSH_DEBOUNCE_EN.
module push_rr_arbiter
    import push_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned HOLD_MAX  = DEF_HOLD_MAX,
    parameter int unsigned COOL      = DEF_COOL,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input logic              clock,
    input logic              reset,
    push_rr_arbiter_if.slave bus
);
    localparam int unsigned IW   = $clog2(N);
    localparam int unsigned TMAX = (HOLD_MAX > COOL) ? HOLD_MAX : COOL;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    if (N < 2) begin : g_bad_n
        $error("push_rr_arbiter: N must be at least 2");
    end
    if (HOLD_MAX < 1 || COOL < 1 || DB_CYCLES < 1) begin : g_bad_timing
        $error("push_rr_arbiter: HOLD_MAX, COOL and DB_CYCLES must be at least 1");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]  lvl_q, lvl_d, level, rise;
    logic [N-1:0]  ptr_q, ptr_d, pending_q, pending_d, gsel_q, gsel_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic          timeout_q, timeout_d, grant_fire;
    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          any_valid;

    push_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .pending   (pending_q),
        .ptr       (ptr_q),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .any_valid (any_valid)
    );

`ifdef PUSH_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

    logic [DBW-1:0] db_cnt_q [N];
    logic [DBW-1:0] db_cnt_d [N];
    logic [N-1:0]   filt_q, filt_d;

    // Filtered level follows the synchronized bit only after DB_CYCLES differing samples in a row.
    always_comb begin
        filt_d = filt_q;
        for (int unsigned i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // Debounce counters and filtered level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
            end
            filt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
            filt_q   <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~lvl_q;

    // State register plus all datapath flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            ptr_q     <= N'(1);
            pending_q <= '0;
            gsel_q    <= '0;
            gidx_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            lvl_q     <= lvl_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            gsel_q    <= gsel_d;
            gidx_q    <= gidx_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: grant from IDLE, release on ack or hold expiry, then cool down.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        timeout_d  = 1'b0;
        grant_fire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.enable && any_valid) begin
                    state_d    = S_GRANT;
                    timer_d    = '0;
                    grant_fire = 1'b1;
                end
            end
            S_GRANT: begin
                if (bus.ack) begin
                    state_d = S_COOL;
                    timer_d = '0;
                end else if (timer_q == TW'(HOLD_MAX - 1)) begin
                    state_d   = S_COOL;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_COOL: begin
                if (timer_q == TW'(COOL - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Input capture, pending set/clear, pointer rotation and grant latch.
    // A new press lands after the winner's clear so it is never lost.
    always_comb begin
        sync1_d   = bus.req;
        sync2_d   = sync1_q;
        lvl_d     = level;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        gsel_d    = gsel_q;
        gidx_d    = gidx_q;
        if (grant_fire) begin
            pending_d = pending_d & ~win_oh;
            gsel_d    = win_oh;
            gidx_d    = win_idx;
        end
        pending_d = pending_d | rise;
        if (!$onehot(ptr_q)) begin
            ptr_d = N'(1);
        end else if (grant_fire) begin
            ptr_d = {win_oh[N-2:0], win_oh[N-1]};
        end
    end

    // Outputs decoded from state so reset clears them without a clock.
    always_comb begin
        bus.gnt       = (state_q == S_GRANT) ? gsel_q : '0;
        bus.gnt_idx   = (state_q == S_GRANT) ? gidx_q : '0;
        bus.gnt_valid = (state_q == S_GRANT);
        bus.busy      = (state_q != S_IDLE);
        bus.pending   = pending_q;
        bus.timeout   = timeout_q;
    end
endmodule

// File: tb/tb_push_rr_arbiter.sv
// Directed bench for push_rr_arbiter (default build, no input debounce).
module tb_push_rr_arbiter;
    import push_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    push_rr_arbiter_if #(.N(8)) ifc ();

    push_rr_arbiter #(
        .N         (8),
        .HOLD_MAX  (16),
        .COOL      (2),
        .DB_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold the mask high across two edges, drop it, then one more edge: pending is visible.
    task automatic press(input logic [7:0] mask);
        ifc.req = mask;
        tick();
        tick();
        ifc.req = '0;
        tick();
    endtask

    // Expects an active grant, acks it after 3 GRANT cycles, waits out COOL.
    task automatic serve(input string tag, input logic [7:0] oh, input int unsigned idx);
        check({tag, "_gnt"}, 32'(ifc.gnt), 32'(oh));
        check({tag, "_idx"}, 32'(ifc.gnt_idx), idx);
        tick();
        tick();
        check({tag, "_hold"}, 32'(ifc.gnt), 32'(oh));
        ifc.ack = 1'b1;
        tick();
        ifc.ack = 1'b0;
        check({tag, "_rel"}, 32'(ifc.gnt), 32'h0);
        tick();
        tick();
        check({tag, "_idle"}, 32'(ifc.busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned held;
        ifc.enable = 1'b1;
        ifc.req    = '0;
        ifc.ack    = 1'b0;

        // Reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("rst_gnt",     32'(ifc.gnt),       32'h0);
        check("rst_valid",   32'(ifc.gnt_valid), 32'h0);
        check("rst_pending", 32'(ifc.pending),   32'h0);
        check("rst_busy",    32'(ifc.busy),      32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_ptr",     32'(dut.ptr_q),     32'h01);
        check("rst_timeout", 32'(ifc.timeout),   32'h0);

        // Single request on bit 3.
        press(8'h08);
        check("single_pending", 32'(ifc.pending),   32'h08);
        check("single_novalid", 32'(ifc.gnt_valid), 32'h0);
        tick();
        check("single_gnt",   32'(ifc.gnt),       32'h08);
        check("single_idx",   32'(ifc.gnt_idx),   32'd3);
        check("single_valid", 32'(ifc.gnt_valid), 32'h1);
        check("single_clr",   32'(ifc.pending),   32'h0);
        ifc.ack = 1'b1;
        tick();
        ifc.ack = 1'b0;
        check("single_rel",   32'(ifc.gnt),  32'h0);
        tick();
        check("single_cool",  32'(ifc.busy), 32'h1);
        tick();
        check("single_idle",  32'(ifc.busy), 32'h0);
        check("single_ptr",   32'(dut.ptr_q), 32'h10);

        // Fairness from ptr=bit4 with 1,5,6 pending: order 5, 6, 1.
        press(8'h62);
        check("fair_pending", 32'(ifc.pending), 32'h62);
        tick();
        serve("fair5", 8'h20, 5);
        check("fair_pending2", 32'(ifc.pending), 32'h42);
        tick();
        serve("fair6", 8'h40, 6);
        tick();
        serve("fair1", 8'h02, 1);
        check("fair_ptr", 32'(dut.ptr_q), 32'h04);

        // Forced release after 16 GRANT cycles.
        press(8'h01);
        tick();
        check("to_gnt", 32'(ifc.gnt), 32'h01);
        held = 0;
        repeat (15) begin
            tick();
            if (ifc.gnt == 8'h01) held++;
        end
        check("to_held", held, 32'd15);
        check("to_nopulse", 32'(ifc.timeout), 32'h0);
        tick();
        check("to_rel",   32'(ifc.gnt),     32'h0);
        check("to_pulse", 32'(ifc.timeout), 32'h1);
        check("to_busy",  32'(ifc.busy),    32'h1);
        tick();
        check("to_pulse_end", 32'(ifc.timeout), 32'h0);
        tick();
        check("to_idle", 32'(ifc.busy), 32'h0);

        // Ack in the 16th GRANT cycle beats the timeout.
        press(8'h01);
        tick();
        check("toack_gnt", 32'(ifc.gnt), 32'h01);
        repeat (15) tick();
        check("toack_last", 32'(ifc.gnt), 32'h01);
        ifc.ack = 1'b1;
        tick();
        ifc.ack = 1'b0;
        check("toack_rel",  32'(ifc.gnt),     32'h0);
        check("toack_nopulse", 32'(ifc.timeout), 32'h0);
        tick();
        tick();
        check("toack_idle", 32'(ifc.busy), 32'h0);

        // Enable gating: capture continues, grants wait.
        ifc.enable = 1'b0;
        press(8'h04);
        check("en_pending", 32'(ifc.pending), 32'h04);
        held = 0;
        repeat (20) begin
            tick();
            if (ifc.gnt_valid) held++;
        end
        check("en_nogrant", held, 32'd0);
        check("en_pending_kept", 32'(ifc.pending), 32'h04);
        ifc.enable = 1'b1;
        tick();
        check("en_gnt", 32'(ifc.gnt),     32'h04);
        check("en_idx", 32'(ifc.gnt_idx), 32'd2);
        ifc.enable = 1'b0;
        tick();
        tick();
        check("en_fall_hold", 32'(ifc.gnt), 32'h04);
        ifc.enable = 1'b1;

        // Asynchronous reset in the middle of a grant.
        press(8'h40);
        check("ar_pending", 32'(ifc.pending), 32'h40);
        check("ar_ingrant", 32'(ifc.gnt),     32'h04);
        #3 reset = 1'b1;
        #1;
        check("ar_gnt",     32'(ifc.gnt),       32'h0);
        check("ar_valid",   32'(ifc.gnt_valid), 32'h0);
        check("ar_busy",    32'(ifc.busy),      32'h0);
        check("ar_pending_clr", 32'(ifc.pending), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("ar_noresume", 32'(ifc.gnt_valid), 32'h0);
        check("ar_ptr",      32'(dut.ptr_q),     32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
